// File: rtl/lane_select_tracker_if.sv
// Lane operand / result handshake bundle between the controller and the lane select tracker.
interface lane_select_tracker_if #(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned IDX_W   = $clog2(N_LANES)
) ();

  logic                       start;
  logic [N_LANES*WIDTH-1:0]   lanes_in;
  logic                       in_valid;
  logic                       out_ready;
  logic                       out_valid;
  logic [IDX_W-1:0]           idx;
  logic                       done;
  logic                       multi_err;
  logic                       timeout;
  logic                       busy;

  // Controller side: drives operands and result acceptance.
  modport master (
    output start, lanes_in, in_valid, out_ready,
    input  out_valid, idx, done, multi_err, timeout, busy
  );

  // Tracker side.
  modport slave (
    input  start, lanes_in, in_valid, out_ready,
    output out_valid, idx, done, multi_err, timeout, busy
  );

endinterface

// File: rtl/lane_select_tracker.sv
// Reports the index of the sole nonzero operand lane once it has been stable for
// HOLD_CYC accepted beats; flags multi-lane conflicts and scan timeouts.
module lane_select_tracker #(
  parameter int unsigned N_LANES  = 4,
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned IDX_W    = $clog2(N_LANES),
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lane_select_tracker_if.slave bus
);

  localparam int unsigned HCNT_W = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);
  localparam int unsigned TCNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_cand;
  logic [HCNT_W-1:0]   r_hcnt;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_out_valid;
  logic [IDX_W-1:0]    r_idx;
  logic                r_done;
  logic                r_multi_err;
  logic                r_timeout;
  logic                r_busy;

  state_t              w_state_nxt;
  logic [IDX_W-1:0]    w_cand_nxt;
  logic [HCNT_W-1:0]   w_hcnt_nxt;
  logic [TCNT_W-1:0]   w_tcnt_nxt;
  logic                w_out_valid_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_done_nxt;
  logic                w_multi_err_nxt;
  logic                w_timeout_nxt;

  logic [N_LANES-1:0]  w_nz;
  logic                w_single;
  logic                w_multi;
  logic [IDX_W-1:0]    w_enc;
  logic [HCNT_W-1:0]   w_hcnt_inc;

  // Per-lane nonzero detection.
  always_comb begin
    w_nz = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      w_nz[i] = |bus.lanes_in[i*WIDTH +: WIDTH];
    end
  end

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign w_multi    = |(w_nz & (w_nz - N_LANES'(1)));
  assign w_single   = (|w_nz) && !w_multi;
  assign w_hcnt_inc = r_hcnt + HCNT_W'(1);

  // Position of the set nonzero flag; only meaningful when w_single.
  always_comb begin
    w_enc = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (w_nz[i]) w_enc = IDX_W'(i);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cand_nxt      = r_cand;
    w_hcnt_nxt      = r_hcnt;
    w_tcnt_nxt      = r_tcnt;
    w_out_valid_nxt = r_out_valid;
    w_idx_nxt       = r_idx;
    w_done_nxt      = 1'b0;
    w_multi_err_nxt = r_multi_err;
    w_timeout_nxt   = r_timeout;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt     = ST_SCAN;
          w_multi_err_nxt = 1'b0;
          w_timeout_nxt   = 1'b0;
          w_hcnt_nxt      = '0;
          w_tcnt_nxt      = '0;
        end
      end
      ST_SCAN: begin
        if (bus.in_valid) begin
          if (w_single) begin
            w_cand_nxt  = w_enc;
            w_hcnt_nxt  = HCNT_W'(1);
            w_state_nxt = (HOLD_CYC == 1) ? ST_REPORT : ST_HOLD;
          end else if (w_multi) begin
            w_multi_err_nxt = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (bus.in_valid) begin
          if (w_single && (w_enc == r_cand)) begin
            w_hcnt_nxt = w_hcnt_inc;
            if (w_hcnt_inc == HCNT_W'(HOLD_CYC)) w_state_nxt = ST_REPORT;
          end else if (w_single) begin
            w_cand_nxt = w_enc;
            w_hcnt_nxt = HCNT_W'(1);
          end else begin
            if (w_multi) w_multi_err_nxt = 1'b1;
            w_hcnt_nxt  = '0;
            w_state_nxt = ST_SCAN;
          end
        end
      end
      ST_REPORT: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_done_nxt      = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Scan-window bookkeeping: report entry takes priority over timeout.
    if ((r_state == ST_SCAN) || (r_state == ST_HOLD)) begin
      if (r_tcnt != '1) w_tcnt_nxt = r_tcnt + TCNT_W'(1);
      if (w_state_nxt == ST_REPORT) begin
        w_out_valid_nxt = 1'b1;
        w_idx_nxt       = w_cand_nxt;
      end else if ((TIMEOUT != 0) && (r_tcnt == TCNT_W'(TIMEOUT - 1))) begin
        w_timeout_nxt = 1'b1;
        w_hcnt_nxt    = '0;
        w_state_nxt   = ST_IDLE;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cand      <= '0;
      r_hcnt      <= '0;
      r_tcnt      <= '0;
      r_out_valid <= 1'b0;
      r_idx       <= '0;
      r_done      <= 1'b0;
      r_multi_err <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_hcnt      <= w_hcnt_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_idx       <= w_idx_nxt;
      r_done      <= w_done_nxt;
      r_multi_err <= w_multi_err_nxt;
      r_timeout   <= w_timeout_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.idx       = r_idx;
  assign bus.done      = r_done;
  assign bus.multi_err = r_multi_err;
  assign bus.timeout   = r_timeout;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_lane_select_tracker.sv
// Directed bench for lane_select_tracker with a result scoreboard.
module tb_lane_select_tracker;

  localparam int unsigned N_LANES = 4;
  localparam int unsigned WIDTH   = 5;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned LW      = N_LANES * WIDTH;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             merr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_err;
  int   n_chk;
  exp_t q[$];
  logic exp_done;

  lane_select_tracker_if #(.N_LANES(N_LANES), .WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  lane_select_tracker #(
    .N_LANES(N_LANES), .WIDTH(WIDTH), .IDX_W(IDX_W), .HOLD_CYC(2), .TIMEOUT(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] mk(input int lane, input logic [WIDTH-1:0] v);
    logic [LW-1:0] r;
    r = '0;
    r[lane*WIDTH +: WIDTH] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [LW-1:0] l, input logic v);
    bus.lanes_in = l;
    bus.in_valid = v;
    tick();
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Monitor: pops an expected result on every handshake and checks done one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_done = 1'b0;
    end else begin
      if (bus.done || exp_done) chk("done_pulse", 32'(bus.done), 32'(exp_done));
      exp_done = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        exp_done = 1'b1;
        if (q.size() == 0) begin
          chk("unexpected_result", 32'(bus.out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("result_idx", 32'(bus.idx), 32'(e.idx));
          chk("result_multi_err", 32'(bus.multi_err), 32'(e.merr));
        end
      end
    end
  end

  initial begin
    n_err = 0;
    n_chk = 0;
    exp_done = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.lanes_in = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_idx", 32'(bus.idx), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_multi_err", 32'(bus.multi_err), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    chk("rst_busy", 32'(bus.busy), 0);

    // Nominal: lane 1 stable for two beats.
    bus.out_ready = 1'b1;
    q.push_back('{idx: 2'd1, merr: 1'b0});
    do_start();
    chk("nom_busy", 32'(bus.busy), 1);
    beat(mk(1, 5'h07), 1'b1);
    chk("nom_no_early", 32'(bus.out_valid), 0);
    beat(mk(1, 5'h07), 1'b1);
    chk("nom_latency_valid", 32'(bus.out_valid), 1);
    chk("nom_latency_idx", 32'(bus.idx), 1);
    bus.in_valid = 1'b0;
    tick();
    chk("nom_done", 32'(bus.done), 1);
    chk("nom_idle", 32'(bus.busy), 0);
    tick();
    chk("nom_done_once", 32'(bus.done), 0);

    // Index change restarts the hold count.
    q.push_back('{idx: 2'd0, merr: 1'b0});
    do_start();
    beat(mk(2, 5'h01), 1'b1);
    beat(mk(0, 5'h10), 1'b1);
    chk("idxchg_no_report", 32'(bus.out_valid), 0);
    beat(mk(0, 5'h10), 1'b1);
    chk("idxchg_report", 32'(bus.out_valid), 1);
    bus.in_valid = 1'b0;
    tick();
    tick();

    // Conflict beat followed by a clean lane 3.
    q.push_back('{idx: 2'd3, merr: 1'b1});
    do_start();
    beat(mk(1, 5'd3) | mk(3, 5'd9), 1'b1);
    chk("conf_multi_err", 32'(bus.multi_err), 1);
    chk("conf_stay_scan", 32'(bus.out_valid), 0);
    beat(mk(3, 5'd9), 1'b1);
    beat(mk(3, 5'd9), 1'b1);
    chk("conf_report", 32'(bus.out_valid), 1);
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("conf_merr_sticky", 32'(bus.multi_err), 1);

    // Backpressure: result held stable while lanes change underneath.
    bus.out_ready = 1'b0;
    q.push_back('{idx: 2'd2, merr: 1'b0});
    do_start();
    chk("bp_merr_cleared", 32'(bus.multi_err), 0);
    beat(mk(2, 5'd4), 1'b1);
    beat(mk(2, 5'd4), 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_held", 32'(bus.out_valid), 1);
      chk("bp_idx_held", 32'(bus.idx), 2);
      beat(mk(1, 5'd1) | mk(3, 5'd2), 1'b1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("bp_idle", 32'(bus.busy), 0);
    chk("bp_idx_kept", 32'(bus.idx), 2);

    // Asynchronous reset in the middle of HOLD with candidate 2.
    do_start();
    beat(mk(2, 5'd6), 1'b1);
    chk("rst_pre_busy", 32'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_idx", 32'(bus.idx), 0);
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("arst_post_busy", 32'(bus.busy), 0);
    chk("arst_post_valid", 32'(bus.out_valid), 0);
    bus.in_valid = 1'b0;

    // Timeout with only all-zero beats.
    do_start();
    for (int k = 0; k < 7; k++) begin
      beat('0, 1'b1);
      chk("to_still_busy", 32'(bus.busy), 1);
      chk("to_not_yet", 32'(bus.timeout), 0);
    end
    beat('0, 1'b1);
    chk("to_flag", 32'(bus.timeout), 1);
    chk("to_busy_low", 32'(bus.busy), 0);
    chk("to_no_valid", 32'(bus.out_valid), 0);
    bus.in_valid = 1'b0;
    tick();
    chk("to_sticky", 32'(bus.timeout), 1);
    q.push_back('{idx: 2'd0, merr: 1'b0});
    do_start();
    chk("to_cleared", 32'(bus.timeout), 0);
    chk("to_restart_busy", 32'(bus.busy), 1);
    beat(mk(0, 5'h1f), 1'b1);
    beat(mk(0, 5'h1f), 1'b1);
    chk("to_recover_valid", 32'(bus.out_valid), 1);
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();

    chk("sb_drain", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lane_select_tracker.md
Name: lane_select_tracker

Overview:
- Parametrised, sequential successor to the combinational single-nonzero lane detector used in the matrix datapath.
- Watches N_LANES operand lanes of WIDTH bits. Reports the index of the sole nonzero lane once that condition has held for HOLD_CYC accepted input beats.
- Delivers the result over a valid/ready handshake to the controller.
- Flags multi-nonzero conflicts and scan timeouts.

Parameters:
- N_LANES, 4, number of input lanes (>=2).
- WIDTH, 5, bits per lane.
- IDX_W, $clog2(N_LANES), width of idx.
- HOLD_CYC, 2, consecutive qualifying beats required before reporting (>=1).
- TIMEOUT, 64, clock cycles allowed in SCAN+HOLD before abort; 0 disables.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a scan; accepted only in IDLE.
- lanes_in  input  N_LANES*WIDTH  packed lanes; lane i = lanes_in[i*WIDTH +: WIDTH].
- in_valid  input  1  lanes_in valid this cycle.
- out_ready  input  1  consumer accepts result.
- out_valid  output  1  result available.
- idx  output  IDX_W  index of the sole nonzero lane (lane 0 -> 0).
- done  output  1  one-cycle pulse on result handshake.
- multi_err  output  1  sticky: a beat with >=2 nonzero lanes was seen this scan.
- timeout  output  1  sticky: scan aborted by TIMEOUT.
- busy  output  1  high in SCAN, HOLD, REPORT.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. out_valid, idx, done, multi_err, timeout, busy all 0. Candidate, hold counter and timeout counter cleared. Reset mid-scan aborts immediately. No result is emitted.
- Combinational qualification per beat:
  - nz[i] = |lane i.
  - single = (popcount(nz)==1).
  - multi = (popcount(nz)>=2).
  - enc = position of the set nz bit.
- IDLE:
  - start=1 -> SCAN next cycle.
  - On that transition, clear multi_err, timeout, hold counter and timeout counter.
- SCAN (beats with in_valid=1 only; in_valid=0 beats change nothing except the timeout counter):
  - single: cand<=enc, hcnt<=1. Go to REPORT if HOLD_CYC==1, else HOLD.
  - multi: multi_err<=1, stay.
  - zero lanes: stay.
- HOLD (in_valid=1 beats only):
  - single & enc==cand: hcnt+1. When the new value equals HOLD_CYC, go REPORT.
  - single & enc!=cand: cand<=enc, hcnt<=1, stay in HOLD.
  - multi: multi_err<=1, hcnt<=0, go SCAN.
  - zero: hcnt<=0, go SCAN.
- Timeout:
  - tcnt increments every clock in SCAN/HOLD.
  - If TIMEOUT!=0 and tcnt reaches TIMEOUT-1 without entering REPORT: timeout<=1, go IDLE, no out_valid.
  - If timeout and REPORT entry fall on the same edge, REPORT wins.
- REPORT:
  - out_valid=1, idx=cand, held stable until the handshake.
  - lanes_in and in_valid are ignored.
  - On out_valid & out_ready: done=1 for exactly that next cycle (registered), out_valid<=0, go IDLE.
  - out_ready=1 on the REPORT entry cycle is honoured, giving minimum latency.
- Latency:
  - start -> SCAN: 1 cycle.
  - First qualifying beat to out_valid: HOLD_CYC cycles when in_valid is continuous.
  - out_valid&out_ready -> done: 1 cycle.
- Other rules:
  - start while busy is ignored.
  - multi_err and timeout remain readable after return to IDLE, until the next accepted start.
  - idx holds its last value after the handshake.
  - hcnt width is $clog2(HOLD_CYC+1). tcnt width is $clog2(TIMEOUT+1). Neither counter wraps.

Test Plan:
- Reset/idle: rst_n=0 mid-HOLD with cand=2 -> all outputs 0 asynchronously. After release, state IDLE and no done pulse.
- Nominal: start, then lanes {L3=0,L2=0,L1=5'h07,L0=0} valid for 2 beats, out_ready=1 -> out_valid with idx=1 on the 2nd beat's following cycle, done one cycle later, multi_err=0.
- Index change: beats L2=5'h01, then L0=5'h10, then L0=5'h10 -> no report after beat 2. Report idx=0 after beat 3.
- Conflict: beat with L1=3 and L3=9, then two beats with only L3=9 -> multi_err=1, final idx=3, done pulses.
- Backpressure: out_ready=0 for 5 cycles in REPORT with idx=2 -> out_valid and idx stable, lane changes ignored. out_ready=1 -> single done pulse.
- Timeout: TIMEOUT=8, only all-zero beats -> after 8 cycles in SCAN, timeout=1, busy=0, out_valid never asserted. Next start clears timeout.
